alu_issue_stage: RTL and testbench

Issue stage directly upstream of the ALU. It decodes RV32IM + Zbb-subset + FADD/FSUB instruction fields into the ALU's 5-bit operation code and resolves operand forwarding. It registers `aluoperation` / `src1` / `src2` behind a valid/ready handshake, so the ALU sees stable operands for one full cycle. It also performs load-use stalls and pipeline flush.

---
 rtl/alu_issue_stage.sv | 301 ++++++++++++++++++++++++++++++
 tb/tb_alu_issue_stage.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_stage.sv
// ALU issue stage: decodes the instruction into an ALU op code, forwards operands, and registers them behind valid/ready.
// Latency 1 cycle. Outputs hold while the ALU stalls; load-use hazards and a stalled full stage drop o_ready.
module alu_issue_stage #(
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [31:0]     i_instr,
    input  logic [31:0]     i_pc,
    input  logic [XLEN-1:0] i_rs1_data,
    input  logic [XLEN-1:0] i_rs2_data,
    input  logic [XLEN-1:0] i_imm,
    input  logic            i_exmem_wen,
    input  logic            i_exmem_load,
    input  logic [4:0]      i_exmem_rd,
    input  logic [XLEN-1:0] i_exmem_data,
    input  logic            i_memwb_wen,
    input  logic [4:0]      i_memwb_rd,
    input  logic [XLEN-1:0] i_memwb_data,
    input  logic            i_flush,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [4:0]      o_aluoperation,
    output logic [XLEN-1:0] o_src1,
    output logic [XLEN-1:0] o_src2,
    output logic [4:0]      o_rd,
    output logic            o_rd_wen,
    output logic            o_illegal
);

    localparam logic [4:0] OP_ADD     = 5'd0;
    localparam logic [4:0] OP_SUB     = 5'd1;
    localparam logic [4:0] OP_SLL     = 5'd2;
    localparam logic [4:0] OP_SLT     = 5'd3;
    localparam logic [4:0] OP_SLTU    = 5'd4;
    localparam logic [4:0] OP_XOR     = 5'd5;
    localparam logic [4:0] OP_SRL     = 5'd6;
    localparam logic [4:0] OP_SRA     = 5'd7;
    localparam logic [4:0] OP_OR      = 5'd8;
    localparam logic [4:0] OP_AND     = 5'd9;
    localparam logic [4:0] OP_MUL     = 5'd10;
    localparam logic [4:0] OP_MULH    = 5'd11;
    localparam logic [4:0] OP_MULHSU  = 5'd12;
    localparam logic [4:0] OP_MULHU   = 5'd13;
    localparam logic [4:0] OP_EQUAL   = 5'd14;
    localparam logic [4:0] OP_NEQUAL  = 5'd15;
    localparam logic [4:0] OP_S_LT    = 5'd16;
    localparam logic [4:0] OP_S_GE    = 5'd17;
    localparam logic [4:0] OP_U_LT    = 5'd18;
    localparam logic [4:0] OP_U_GE    = 5'd19;
    localparam logic [4:0] OP_FADD    = 5'd20;
    localparam logic [4:0] OP_FSUB    = 5'd21;
    localparam logic [4:0] OP_ANDN    = 5'd22;
    localparam logic [4:0] OP_ORN     = 5'd23;
    localparam logic [4:0] OP_XNOR    = 5'd24;
    localparam logic [4:0] OP_MAX     = 5'd25;
    localparam logic [4:0] OP_MAXU    = 5'd26;
    localparam logic [4:0] OP_MIN     = 5'd27;
    localparam logic [4:0] OP_MINU    = 5'd28;
    localparam logic [4:0] OP_SEXTB   = 5'd29;
    localparam logic [4:0] OP_RETURN1 = 5'd31;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPFP   = 7'b1010011;

    typedef enum logic [1:0] {SEL_REG, SEL_ZERO, SEL_PC, SEL_IMM} src_sel_t;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] rs1, rs2, rd;

    assign opcode = i_instr[6:0];
    assign rd     = i_instr[11:7];
    assign funct3 = i_instr[14:12];
    assign rs1    = i_instr[19:15];
    assign rs2    = i_instr[24:20];
    assign funct7 = i_instr[31:25];

    logic [4:0] dec_op;
    logic       dec_legal;
    logic       dec_no_wr;
    logic       use_rs1, use_rs2;
    src_sel_t   sel1;
    logic [1:0] sel2;   // 0 reg, 1 imm, 2 constant four

    function automatic logic [4:0] base_op(input logic [2:0] f3);
        case (f3)
            3'd0:    return OP_ADD;
            3'd1:    return OP_SLL;
            3'd2:    return OP_SLT;
            3'd3:    return OP_SLTU;
            3'd4:    return OP_XOR;
            3'd5:    return OP_SRL;
            3'd6:    return OP_OR;
            default: return OP_AND;
        endcase
    endfunction

    always_comb begin
        dec_op    = OP_RETURN1;
        dec_no_wr = 1'b0;
        use_rs1   = 1'b0;
        use_rs2   = 1'b0;
        sel1      = SEL_REG;
        sel2      = 2'd0;
        case (opcode)
            OPC_OP: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                case (funct7)
                    7'h00: dec_op = base_op(funct3);
                    7'h20: begin
                        case (funct3)
                            3'd0:    dec_op = OP_SUB;
                            3'd4:    dec_op = OP_XNOR;
                            3'd5:    dec_op = OP_SRA;
                            3'd6:    dec_op = OP_ORN;
                            3'd7:    dec_op = OP_ANDN;
                            default: dec_op = OP_RETURN1;
                        endcase
                    end
                    7'h01: begin
                        case (funct3)
                            3'd0:    dec_op = OP_MUL;
                            3'd1:    dec_op = OP_MULH;
                            3'd2:    dec_op = OP_MULHSU;
                            3'd3:    dec_op = OP_MULHU;
                            default: dec_op = OP_RETURN1;
                        endcase
                    end
                    7'h05: begin
                        case (funct3)
                            3'd4:    dec_op = OP_MIN;
                            3'd5:    dec_op = OP_MINU;
                            3'd6:    dec_op = OP_MAX;
                            3'd7:    dec_op = OP_MAXU;
                            default: dec_op = OP_RETURN1;
                        endcase
                    end
                    default: dec_op = OP_RETURN1;
                endcase
            end
            OPC_OPIMM: begin
                use_rs1 = 1'b1;
                sel2    = 2'd1;
                case (funct3)
                    3'd1: begin
                        if (funct7 == 7'h00)
                            dec_op = OP_SLL;
                        else if (funct7 == 7'h30 && rs2 == 5'd4)
                            dec_op = OP_SEXTB;
                        else
                            dec_op = OP_RETURN1;
                    end
                    3'd5: begin
                        if (funct7 == 7'h00)
                            dec_op = OP_SRL;
                        else if (funct7 == 7'h20)
                            dec_op = OP_SRA;
                        else
                            dec_op = OP_RETURN1;
                    end
                    default: dec_op = base_op(funct3);
                endcase
            end
            OPC_BRANCH: begin
                use_rs1   = 1'b1;
                use_rs2   = 1'b1;
                dec_no_wr = 1'b1;
                case (funct3)
                    3'd0:    dec_op = OP_EQUAL;
                    3'd1:    dec_op = OP_NEQUAL;
                    3'd4:    dec_op = OP_S_LT;
                    3'd5:    dec_op = OP_S_GE;
                    3'd6:    dec_op = OP_U_LT;
                    3'd7:    dec_op = OP_U_GE;
                    default: dec_op = OP_RETURN1;
                endcase
            end
            OPC_LUI: begin
                dec_op = OP_ADD;
                sel1   = SEL_ZERO;
                sel2   = 2'd1;
            end
            OPC_AUIPC: begin
                dec_op = OP_ADD;
                sel1   = SEL_PC;
                sel2   = 2'd1;
            end
            OPC_JAL, OPC_JALR: begin
                dec_op = OP_ADD;
                sel1   = SEL_PC;
                sel2   = 2'd2;
            end
            OPC_LOAD, OPC_STORE: begin
                dec_op    = OP_ADD;
                use_rs1   = 1'b1;
                sel2      = 2'd1;
                dec_no_wr = (opcode == OPC_STORE);
            end
            OPC_OPFP: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                case (funct7)
                    7'h00:   dec_op = OP_FADD;
                    7'h04:   dec_op = OP_FSUB;
                    default: dec_op = OP_RETURN1;
                endcase
            end
            default: dec_op = OP_RETURN1;
        endcase
        // Illegal encodings read nothing, so they can neither forward nor stall.
        if (dec_op == OP_RETURN1) begin
            use_rs1 = 1'b0;
            use_rs2 = 1'b0;
            sel1    = SEL_ZERO;
            sel2    = 2'd3;
        end
    end

    assign dec_legal = (dec_op != OP_RETURN1);

    logic [XLEN-1:0] fwd_rs1, fwd_rs2;
    logic [XLEN-1:0] nxt_src1, nxt_src2;

    always_comb begin
        fwd_rs1 = i_rs1_data;
        if (rs1 != 5'd0 && i_exmem_wen && i_exmem_rd == rs1)
            fwd_rs1 = i_exmem_data;
        else if (rs1 != 5'd0 && i_memwb_wen && i_memwb_rd == rs1)
            fwd_rs1 = i_memwb_data;

        fwd_rs2 = i_rs2_data;
        if (rs2 != 5'd0 && i_exmem_wen && i_exmem_rd == rs2)
            fwd_rs2 = i_exmem_data;
        else if (rs2 != 5'd0 && i_memwb_wen && i_memwb_rd == rs2)
            fwd_rs2 = i_memwb_data;
    end

    always_comb begin
        case (sel1)
            SEL_REG: nxt_src1 = fwd_rs1;
            SEL_PC:  nxt_src1 = XLEN'(i_pc);
            default: nxt_src1 = '0;
        endcase
        case (sel2)
            2'd0:    nxt_src2 = fwd_rs2;
            2'd1:    nxt_src2 = i_imm;
            2'd2:    nxt_src2 = XLEN'(4);
            default: nxt_src2 = '0;
        endcase
    end

    logic hazard;
    logic capture;

    assign hazard = i_valid && i_exmem_load && i_exmem_rd != 5'd0 &&
                    ((use_rs1 && i_exmem_rd == rs1) || (use_rs2 && i_exmem_rd == rs2));
    assign o_ready = (!o_valid || i_ready) && !hazard;
    assign capture = i_valid && o_ready && !i_flush;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_valid        <= 1'b0;
            o_aluoperation <= '0;
            o_src1         <= '0;
            o_src2         <= '0;
            o_rd           <= '0;
            o_rd_wen       <= 1'b0;
            o_illegal      <= 1'b0;
        end else begin
            if (i_flush)
                o_valid <= 1'b0;
            else if (capture)
                o_valid <= 1'b1;
            else if (i_ready)
                o_valid <= 1'b0;

            if (capture) begin
                o_aluoperation <= dec_op;
                o_src1         <= nxt_src1;
                o_src2         <= nxt_src2;
                o_rd           <= rd;
                o_rd_wen       <= dec_legal && !dec_no_wr && rd != 5'd0;
                o_illegal      <= !dec_legal;
            end
        end
    end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: decode, forwarding, load-use, handshake, flush and reset.
module tb_alu_issue_stage;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_valid;
    logic        o_ready;
    logic [31:0] i_instr, i_pc, i_rs1_data, i_rs2_data, i_imm;
    logic        i_exmem_wen, i_exmem_load;
    logic [4:0]  i_exmem_rd;
    logic [31:0] i_exmem_data;
    logic        i_memwb_wen;
    logic [4:0]  i_memwb_rd;
    logic [31:0] i_memwb_data;
    logic        i_flush;
    logic        o_valid;
    logic        i_ready;
    logic [4:0]  o_aluoperation;
    logic [31:0] o_src1, o_src2;
    logic [4:0]  o_rd;
    logic        o_rd_wen;
    logic        o_illegal;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [6:0] OPC_OP = 7'b0110011;

    alu_issue_stage #(.XLEN(32)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
        .i_instr(i_instr), .i_pc(i_pc), .i_rs1_data(i_rs1_data), .i_rs2_data(i_rs2_data),
        .i_imm(i_imm), .i_exmem_wen(i_exmem_wen), .i_exmem_load(i_exmem_load),
        .i_exmem_rd(i_exmem_rd), .i_exmem_data(i_exmem_data), .i_memwb_wen(i_memwb_wen),
        .i_memwb_rd(i_memwb_rd), .i_memwb_data(i_memwb_data), .i_flush(i_flush),
        .o_valid(o_valid), .i_ready(i_ready), .o_aluoperation(o_aluoperation),
        .o_src1(o_src1), .o_src2(o_src2), .o_rd(o_rd), .o_rd_wen(o_rd_wen),
        .o_illegal(o_illegal)
    );

    always #5 i_clk = ~i_clk;

    function automatic logic [31:0] enc(input logic [6:0] f7, input logic [4:0] r2,
                                        input logic [4:0] r1, input logic [2:0] f3,
                                        input logic [4:0] rdx, input logic [6:0] opc);
        return {f7, r2, r1, f3, rdx, opc};
    endfunction

    task automatic drive_idle();
        i_valid      = 1'b0;
        i_instr      = 32'h0;
        i_pc         = 32'h0;
        i_rs1_data   = 32'h0;
        i_rs2_data   = 32'h0;
        i_imm        = 32'h0;
        i_exmem_wen  = 1'b0;
        i_exmem_load = 1'b0;
        i_exmem_rd   = 5'd0;
        i_exmem_data = 32'h0;
        i_memwb_wen  = 1'b0;
        i_memwb_rd   = 5'd0;
        i_memwb_data = 32'h0;
        i_flush      = 1'b0;
        i_ready      = 1'b1;
    endtask

    task automatic test_reset();
        #1;
        n_checks++;
        if ({o_valid, o_aluoperation, o_rd, o_rd_wen, o_illegal} !== 13'h0) begin
            n_fail++;
            $display("FAIL reset_ctrl got valid=%0b op=%0d rd=%0d wen=%0b ill=%0b want all 0",
                     o_valid, o_aluoperation, o_rd, o_rd_wen, o_illegal);
        end
        n_checks++;
        if (o_src1 !== 32'h0 || o_src2 !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_src got src1=%h src2=%h want 0 0", o_src1, o_src2);
        end
        n_checks++;
        if (o_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready got %b want 1", o_ready);
        end
    endtask

    task automatic test_add();
        i_instr = enc(7'h00, 5'd2, 5'd1, 3'd0, 5'd3, OPC_OP);
        i_rs1_data = 32'd5;
        i_rs2_data = 32'd7;
        i_valid = 1'b1;
        @(negedge i_clk);
        n_checks++;
        if ({o_valid, o_aluoperation, o_rd, o_rd_wen, o_illegal} !== {1'b1, 5'd0, 5'd3, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL add_ctrl got valid=%0b op=%0d rd=%0d wen=%0b ill=%0b want 1 0 3 1 0",
                     o_valid, o_aluoperation, o_rd, o_rd_wen, o_illegal);
        end
        n_checks++;
        if (o_src1 !== 32'd5 || o_src2 !== 32'd7) begin
            n_fail++;
            $display("FAIL add_src got src1=%0d src2=%0d want 5 7", o_src1, o_src2);
        end
        i_valid = 1'b0;
        @(negedge i_clk);
        n_checks++;
        if (o_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL add_drain got valid=%b want 0", o_valid);
        end
    endtask

    task automatic test_forwarding();
        i_instr = enc(7'h00, 5'd2, 5'd4, 3'd0, 5'd6, OPC_OP);
        i_rs1_data = 32'h1111;
        i_rs2_data = 32'h2222;
        i_exmem_wen = 1'b1; i_exmem_rd = 5'd4; i_exmem_data = 32'hAAAA;
        i_memwb_wen = 1'b1; i_memwb_rd = 5'd4; i_memwb_data = 32'hBBBB;
        i_valid = 1'b1;
        @(negedge i_clk);
        n_checks++;
        if (o_src1 !== 32'hAAAA || o_src2 !== 32'h2222) begin
            n_fail++;
            $display("FAIL fwd_exmem_prio got src1=%h src2=%h want aaaa 2222", o_src1, o_src2);
        end
        i_exmem_wen = 1'b0;
        @(negedge i_clk);
        n_checks++;
        if (o_src1 !== 32'hBBBB) begin
            n_fail++;
            $display("FAIL fwd_memwb got src1=%h want bbbb", o_src1);
        end
        i_instr = enc(7'h00, 5'd4, 5'd1, 3'd0, 5'd6, OPC_OP);
        i_exmem_wen = 1'b1; i_exmem_rd = 5'd4; i_exmem_data = 32'hCCCC;
        i_memwb_wen = 1'b0;
        @(negedge i_clk);
        n_checks++;
        if (o_src1 !== 32'h1111 || o_src2 !== 32'hCCCC) begin
            n_fail++;
            $display("FAIL fwd_rs2 got src1=%h src2=%h want 1111 cccc", o_src1, o_src2);
        end
        i_instr = enc(7'h00, 5'd2, 5'd0, 3'd0, 5'd0, OPC_OP);
        i_rs1_data = 32'h0;
        i_exmem_wen = 1'b1; i_exmem_rd = 5'd0; i_exmem_data = 32'h1234;
        i_memwb_wen = 1'b1; i_memwb_rd = 5'd0; i_memwb_data = 32'h5678;
        @(negedge i_clk);
        n_checks++;
        if (o_src1 !== 32'h0 || o_rd_wen !== 1'b0) begin
            n_fail++;
            $display("FAIL fwd_x0 got src1=%h wen=%b want 0 0", o_src1, o_rd_wen);
        end
        drive_idle();
        @(negedge i_clk);
    endtask

    task automatic test_load_use();
        i_instr = enc(7'h00, 5'd1, 5'd5, 3'd0, 5'd7, OPC_OP);
        i_rs1_data = 32'h10;
        i_rs2_data = 32'h20;
        i_exmem_wen = 1'b1; i_exmem_load = 1'b1; i_exmem_rd = 5'd5; i_exmem_data = 32'h55;
        i_valid = 1'b1;
        for (int c = 0; c < 2; c++) begin
            #1;
            n_checks++;
            if (o_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL loaduse_ready cycle %0d got %b want 0", c, o_ready);
            end
            @(negedge i_clk);
            n_checks++;
            if (o_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL loaduse_hold cycle %0d got valid=%b want 0", c, o_valid);
            end
        end
        i_exmem_wen = 1'b0; i_exmem_load = 1'b0; i_exmem_rd = 5'd0;
        i_memwb_wen = 1'b1; i_memwb_rd = 5'd5; i_memwb_data = 32'h99;
        #1;
        n_checks++;
        if (o_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL loaduse_clear got ready=%b want 1", o_ready);
        end
        @(negedge i_clk);
        n_checks++;
        if (o_valid !== 1'b1 || o_src1 !== 32'h99 || o_src2 !== 32'h20 || o_rd !== 5'd7) begin
            n_fail++;
            $display("FAIL loaduse_capture got valid=%b src1=%h src2=%h rd=%0d want 1 99 20 7",
                     o_valid, o_src1, o_src2, o_rd);
        end
        drive_idle();
        @(negedge i_clk);
    endtask

    task automatic test_back_to_back();
        i_instr = enc(7'h00, 5'd2, 5'd1, 3'd0, 5'd3, OPC_OP);
        i_rs1_data = 32'd1;
        i_rs2_data = 32'd2;
        i_valid = 1'b1;
        @(negedge i_clk);
        i_ready = 1'b0;
        i_instr = enc(7'h20, 5'd2, 5'd1, 3'd0, 5'd9, OPC_OP);
        i_rs1_data = 32'h10;
        i_rs2_data = 32'h20;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_checks++;
            if (o_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_ready cycle %0d got %b want 0", c, o_ready);
            end
            @(negedge i_clk);
            n_checks++;
            if (o_valid !== 1'b1 || o_aluoperation !== 5'd0 || o_src1 !== 32'd1 ||
                o_src2 !== 32'd2 || o_rd !== 5'd3) begin
                n_fail++;
                $display("FAIL bp_hold cycle %0d got valid=%b op=%0d src1=%h src2=%h rd=%0d want 1 0 1 2 3",
                         c, o_valid, o_aluoperation, o_src1, o_src2, o_rd);
            end
        end
        i_ready = 1'b1;
        #1;
        n_checks++;
        if (o_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_release_ready got %b want 1", o_ready);
        end
        @(negedge i_clk);
        n_checks++;
        if (o_valid !== 1'b1 || o_aluoperation !== 5'd1 || o_src1 !== 32'h10 ||
            o_src2 !== 32'h20 || o_rd !== 5'd9) begin
            n_fail++;
            $display("FAIL bp_next got valid=%b op=%0d src1=%h src2=%h rd=%0d want 1 1 10 20 9",
                     o_valid, o_aluoperation, o_src1, o_src2, o_rd);
        end
        i_valid = 1'b0;
        @(negedge i_clk);
        n_checks++;
        if (o_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_drain got valid=%b want 0", o_valid);
        end
    endtask

    task automatic test_flush();
        i_instr = enc(7'h00, 5'd2, 5'd1, 3'd0, 5'd3, OPC_OP);
        i_valid = 1'b1;
        @(negedge i_clk);
        i_instr = enc(7'h00, 5'd2, 5'd1, 3'd0, 5'd12, OPC_OP);
        i_flush = 1'b1;
        @(negedge i_clk);
        n_checks++;
        if (o_valid !== 1'b0 || o_rd !== 5'd3) begin
            n_fail++;
            $display("FAIL flush got valid=%b rd=%0d want 0 3", o_valid, o_rd);
        end
        drive_idle();
        @(negedge i_clk);
    endtask

    task automatic test_async_reset();
        i_instr = enc(7'h00, 5'd2, 5'd1, 3'd0, 5'd3, OPC_OP);
        i_rs1_data = 32'd5;
        i_rs2_data = 32'd7;
        i_valid = 1'b1;
        @(negedge i_clk);
        #2 i_rst_n = 1'b0;
        #1;
        n_checks++;
        if ({o_valid, o_aluoperation, o_rd, o_rd_wen, o_illegal} !== 13'h0 ||
            o_src1 !== 32'h0 || o_src2 !== 32'h0) begin
            n_fail++;
            $display("FAIL async_reset got valid=%b op=%0d src1=%h src2=%h rd=%0d want all 0",
                     o_valid, o_aluoperation, o_src1, o_src2, o_rd);
        end
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(negedge i_clk);
        n_checks++;
        if (o_valid !== 1'b1 || o_src1 !== 32'd5 || o_rd !== 5'd3) begin
            n_fail++;
            $display("FAIL post_reset_capture got valid=%b src1=%h rd=%0d want 1 5 3",
                     o_valid, o_src1, o_rd);
        end
        drive_idle();
        @(negedge i_clk);
    endtask

    task automatic test_decode();
        logic [31:0] ins [12];
        logic [4:0]  eop [12];
        logic        ewen[12];
        logic        eill[12];
        logic        chk [12];
        logic [31:0] es1 [12];
        logic [31:0] es2 [12];
        ins[0]  = enc(7'h00, 5'd2, 5'd1, 3'd7, 5'd0, 7'b1100011);
        eop[0]  = 5'd19; ewen[0]  = 0; eill[0]  = 0; chk[0]  = 1; es1[0]  = 32'h11;  es2[0]  = 32'h22;
        ins[1]  = enc(7'h04, 5'd2, 5'd1, 3'd0, 5'd3, 7'b1010011);
        eop[1]  = 5'd21; ewen[1]  = 1; eill[1]  = 0; chk[1]  = 1; es1[1]  = 32'h11;  es2[1]  = 32'h22;
        ins[2]  = enc(7'h30, 5'd4, 5'd1, 3'd1, 5'd3, 7'b0010011);
        eop[2]  = 5'd29; ewen[2]  = 1; eill[2]  = 0; chk[2]  = 1; es1[2]  = 32'h11;  es2[2]  = 32'h33;
        ins[3]  = enc(7'h05, 5'd2, 5'd1, 3'd5, 5'd3, OPC_OP);
        eop[3]  = 5'd28; ewen[3]  = 1; eill[3]  = 0; chk[3]  = 1; es1[3]  = 32'h11;  es2[3]  = 32'h22;
        ins[4]  = enc(7'h01, 5'd2, 5'd1, 3'd4, 5'd3, OPC_OP);
        eop[4]  = 5'd31; ewen[4]  = 0; eill[4]  = 1; chk[4]  = 0; es1[4]  = 32'h0;   es2[4]  = 32'h0;
        ins[5]  = enc(7'h00, 5'd0, 5'd0, 3'd0, 5'd1, 7'b1101111);
        eop[5]  = 5'd0;  ewen[5]  = 1; eill[5]  = 0; chk[5]  = 1; es1[5]  = 32'h100; es2[5]  = 32'h4;
        ins[6]  = enc(7'h00, 5'd0, 5'd0, 3'd0, 5'd2, 7'b0110111);
        eop[6]  = 5'd0;  ewen[6]  = 1; eill[6]  = 0; chk[6]  = 1; es1[6]  = 32'h0;   es2[6]  = 32'h33;
        ins[7]  = enc(7'h00, 5'd2, 5'd1, 3'd2, 5'd0, 7'b0100011);
        eop[7]  = 5'd0;  ewen[7]  = 0; eill[7]  = 0; chk[7]  = 1; es1[7]  = 32'h11;  es2[7]  = 32'h33;
        ins[8]  = enc(7'h20, 5'd3, 5'd1, 3'd5, 5'd5, 7'b0010011);
        eop[8]  = 5'd7;  ewen[8]  = 1; eill[8]  = 0; chk[8]  = 1; es1[8]  = 32'h11;  es2[8]  = 32'h33;
        ins[9]  = enc(7'h00, 5'd0, 5'd1, 3'd0, 5'd0, 7'b0010011);
        eop[9]  = 5'd0;  ewen[9]  = 0; eill[9]  = 0; chk[9]  = 1; es1[9]  = 32'h11;  es2[9]  = 32'h33;
        ins[10] = enc(7'h01, 5'd2, 5'd1, 3'd3, 5'd4, OPC_OP);
        eop[10] = 5'd13; ewen[10] = 1; eill[10] = 0; chk[10] = 1; es1[10] = 32'h11;  es2[10] = 32'h22;
        ins[11] = enc(7'h00, 5'd0, 5'd0, 3'd0, 5'd6, 7'b0010111);
        eop[11] = 5'd0;  ewen[11] = 1; eill[11] = 0; chk[11] = 1; es1[11] = 32'h100; es2[11] = 32'h33;
        i_pc = 32'h100;
        i_rs1_data = 32'h11;
        i_rs2_data = 32'h22;
        i_imm = 32'h33;
        i_valid = 1'b1;
        for (int k = 0; k < 12; k++) begin
            i_instr = ins[k];
            @(negedge i_clk);
            n_checks++;
            if (o_valid !== 1'b1 || o_aluoperation !== eop[k] || o_rd_wen !== ewen[k] ||
                o_illegal !== eill[k]) begin
                n_fail++;
                $display("FAIL decode[%0d] got valid=%b op=%0d wen=%b ill=%b want 1 %0d %b %b",
                         k, o_valid, o_aluoperation, o_rd_wen, o_illegal, eop[k], ewen[k], eill[k]);
            end
            if (chk[k]) begin
                n_checks++;
                if (o_src1 !== es1[k] || o_src2 !== es2[k]) begin
                    n_fail++;
                    $display("FAIL decode_src[%0d] got src1=%h src2=%h want %h %h",
                             k, o_src1, o_src2, es1[k], es2[k]);
                end
            end
        end
        drive_idle();
        @(negedge i_clk);
    endtask

    initial begin
        i_rst_n = 1'b0;
        drive_idle();
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;
        test_reset();
        @(negedge i_clk);
        test_add();
        test_forwarding();
        test_load_use();
        test_back_to_back();
        test_flush();
        test_async_reset();
        test_decode();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
